// File: rtl/gray_step_tracker_pkg.sv
// Shared types for the Gray step tracker: FSM states, per-cycle step classes, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gray_step_tracker_pkg;

    // Tracker FSM states. INIT is also the reset state.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Classification of one cycle's movement of the decoded count.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } step_class_e;

    // Width of the saturating illegal-transition counter.
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/gray_step_tracker_gray2bin.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
// Latency: 0 cycles, purely combinational; the caller registers the result.
// Backpressure: none.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic acc;

    // Running XOR from the MSB: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        acc = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_step_tracker.sv
// Tracks an asynchronous Gray-coded counter: decodes it, classifies each move, integrates a position.
// Latency: gray_in change to step pulse is SYNC_STAGES + 2 clk cycles.
// Backpressure: none; every synchronized sample is consumed, illegal moves park the block in FAULT.
module gray_step_tracker
    import gray_step_tracker_pkg::*;
#(
    parameter int W           = 4,
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         gray_in,
    input  logic                 pos_clr,
    input  logic                 clear_err,
    output logic [W-1:0]         bin_out,
    output logic                 step,
    output logic                 dir,
    output logic [POS_W-1:0]     pos,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // The synchronizer resets to zero, so bin_out only reflects a real input sample
    // SYNC_STAGES+1 edges after reset release. INIT is held until then so that the
    // value present at reset release is absorbed rather than seen as a jump from 0.
    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Input synchronizer: plain flop chain, nothing between stages
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [SYNC_STAGES-1:0][W-1:0] sync_src;
    logic [W-1:0]                  g_s;

    // Wiring only: stage 0 takes the raw input, every later stage takes its predecessor.
    always_comb begin
        sync_src[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_src[i] = sync_q[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            // One synchronizer stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q[gi] <= '0;
                end else begin
                    sync_q[gi] <= sync_src[gi];
                end
            end
        end
    endgenerate

    assign g_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Decode and classify
    // ------------------------------------------------------------------
    logic [W-1:0]  bin_d;
    logic [W-1:0]  bin_q;
    logic [W-1:0]  prev_bin_d;
    logic [W-1:0]  prev_bin_q;
    logic [W-1:0]  diff;
    step_class_e   cls;

    gray2bin #(
        .W (W)
    ) u_gray2bin (
        .gray (g_s),
        .bin  (bin_d)
    );

    // Modular difference between this cycle's and last cycle's decoded value,
    // so wrap-around (max -> 0, 0 -> max) classifies as an ordinary step.
    always_comb begin
        diff = bin_q - prev_bin_q;
        if (diff == '0) begin
            cls = HOLD;
        end else if (diff == W'(1)) begin
            cls = UP;
        end else if (diff == '1) begin
            cls = DOWN;
        end else begin
            cls = ILLEGAL;
        end
    end

    // ------------------------------------------------------------------
    // FSM, position integrator, error counter
    // ------------------------------------------------------------------
    state_e                 state_d;
    state_e                 state_q;
    logic                   step_d;
    logic                   step_q;
    logic                   dir_d;
    logic                   dir_q;
    logic [POS_W-1:0]       pos_d;
    logic [POS_W-1:0]       pos_q;
    logic [ERR_CNT_W-1:0]   err_cnt_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [2:0]             fill_d;
    logic [2:0]             fill_q;
    logic                   primed;

    assign primed = (fill_q == FILL_LAST);

    // Next-state and registered-output logic; pos_clr overrides any position update last.
    always_comb begin
        state_d    = state_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        pos_d      = pos_q;
        err_cnt_d  = err_cnt_q;
        prev_bin_d = bin_q;
        fill_d     = primed ? fill_q : fill_q + 3'd1;

        case (state_q)
            INIT: begin
                // prev_bin is loaded unconditionally above; no classification here.
                if (primed) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                case (cls)
                    UP: begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q + POS_W'(1);
                    end
                    DOWN: begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q - POS_W'(1);
                    end
                    ILLEGAL: begin
                        state_d = FAULT;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
            FAULT: begin
                if (clear_err) begin
                    state_d = INIT;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (pos_clr) begin
            pos_d = '0;
        end
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            bin_q      <= '0;
            prev_bin_q <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            pos_q      <= '0;
            err_cnt_q  <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            prev_bin_q <= prev_bin_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            pos_q      <= pos_d;
            err_cnt_q  <= err_cnt_d;
            fill_q     <= fill_d;
        end
    end

    assign bin_out = bin_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign pos     = pos_q;
    assign err_cnt = err_cnt_q;
    assign locked  = (state_q == TRACK);
    assign err     = (state_q == FAULT);

endmodule

// File: tb/tb_gray_step_tracker.sv
// Testbench for gray_step_tracker: reference model of the counter walk plus a step scoreboard.
// Latency: expects each step SYNC_STAGES + 2 cycles after the gray_in change.
// Backpressure: n/a.
module tb_gray_step_tracker;

    localparam int W     = 4;
    localparam int POS_W = 16;
    localparam int S     = 2;
    localparam int MASK  = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     gray_in;
    logic             pos_clr;
    logic             clear_err;
    logic [W-1:0]     bin_out;
    logic             step;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic             locked;
    logic             err;
    logic [7:0]       err_cnt;

    typedef struct {
        logic             dir;
        logic [POS_W-1:0] pos;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: last value driven, integrated position, last direction,
    // error count and whether the tracker should currently be faulted.
    int               m_val;
    logic [POS_W-1:0] m_pos;
    logic             m_dir;
    int               m_errcnt;
    logic             m_fault;

    gray_step_tracker #(
        .W           (W),
        .POS_W       (POS_W),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .pos_clr   (pos_clr),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .step      (step),
        .dir       (dir),
        .pos       (pos),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = W'(b & MASK);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Pops one expectation per observed step pulse; a pulse with nothing queued is a failure.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && step) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_step", step, 0);
                end else begin
                    e = exp_q.pop_front();
                    n_total++;
                    if (dir === e.dir && pos === e.pos && cyc == e.cyc) n_pass++;
                    else $display("FAIL step: got dir=%0d pos=%0h cyc=%0d expected dir=%0d pos=%0h cyc=%0d",
                                  dir, pos, cyc, e.dir, e.pos, e.cyc);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new binary value (as Gray) and hold it; the model decides what the tracker should do.
    task automatic drive(input int v_in, input int hold);
        int v;
        int d;
        v = v_in & MASK;
        d = (v - m_val) & MASK;
        gray_in = to_gray(v);
        if (!m_fault) begin
            if (d == 1) begin
                m_pos = m_pos + 1'b1;
                m_dir = 1'b1;
                exp_q.push_back('{dir: 1'b1, pos: m_pos, cyc: cyc + S + 2});
            end else if (d == MASK) begin
                m_pos = m_pos - 1'b1;
                m_dir = 1'b0;
                exp_q.push_back('{dir: 1'b0, pos: m_pos, cyc: cyc + S + 2});
            end else if (d != 0) begin
                m_fault = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        m_val = v;
        repeat (hold) tick();
    endtask

    // A legal step with pos_clr asserted in exactly the cycle the step registers.
    task automatic step_clr(input logic up);
        int v;
        v = up ? ((m_val + 1) & MASK) : ((m_val - 1) & MASK);
        gray_in = to_gray(v);
        m_val = v;
        m_dir = up;
        m_pos = '0;
        exp_q.push_back('{dir: up, pos: '0, cyc: cyc + S + 2});
        repeat (S + 1) tick();
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic quiet_pos_clr();
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        m_pos = '0;
    endtask

    // Let the pipeline drain, then compare every observable output against the model.
    task automatic checkpoint(input string name);
        repeat (S + 4) @(posedge clk);
        #1;
        chk({name, ".pending_steps"}, exp_q.size(), 0);
        chk({name, ".pos"}, pos, m_pos);
        chk({name, ".dir"}, dir, m_dir);
        chk({name, ".bin_out"}, bin_out, m_val);
        chk({name, ".locked"}, locked, !m_fault);
        chk({name, ".err"}, err, m_fault);
        chk({name, ".err_cnt"}, err_cnt, m_errcnt);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".pos"}, pos, 0);
        chk({name, ".dir"}, dir, 0);
        chk({name, ".step"}, step, 0);
        chk({name, ".bin_out"}, bin_out, 0);
        chk({name, ".locked"}, locked, 0);
        chk({name, ".err"}, err, 0);
        chk({name, ".err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        gray_in   = '0;
        pos_clr   = 1'b0;
        clear_err = 1'b0;
        m_val     = 0;
        m_pos     = '0;
        m_dir     = 1'b0;
        m_errcnt  = 0;
        m_fault   = 1'b0;

        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        checkpoint("post_reset");

        // Counting up through binary 0..3 (Gray 0000,0001,0011,0010).
        drive(1, 4);
        drive(2, 4);
        drive(3, 4);
        checkpoint("count_up");

        // Walk down to 0, then exercise code wrap in both directions.
        drive(2, 4);
        drive(1, 4);
        drive(0, 4);
        drive(15, 4);
        drive(0, 4);
        drive(15, 4);
        drive(0, 4);
        checkpoint("wrap");

        // clear_err outside FAULT does nothing.
        clear_pulse();
        checkpoint("clear_in_track");

        // Illegal jump 1 -> 14, ignored step while faulted, then resync.
        drive(1, 4);
        drive(14, 4);
        checkpoint("fault");
        drive(15, 4);
        checkpoint("fault_ignore");
        clear_pulse();
        checkpoint("fault_cleared");
        drive(0, 3);
        drive(1, 3);
        checkpoint("after_resync");

        // Position wrap at the signed boundary.
        quiet_pos_clr();
        for (int k = 0; k < 32767; k++) drive(m_val + 1, 1);
        checkpoint("pos_7fff");
        drive(m_val + 1, 1);
        checkpoint("pos_8000");
        chk("pos_wrap_value", pos, 16'h8000);

        // pos_clr coinciding with a step: position cleared, pulse and direction kept.
        step_clr(1'b0);
        checkpoint("clr_with_step");

        // Mid-stream reset at pos=5 with a constant non-zero input afterwards.
        quiet_pos_clr();
        for (int k = 0; k < 5; k++) drive(m_val + 1, 2);
        checkpoint("pos5");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        gray_in = to_gray(9);
        exp_q.delete();
        m_val    = 9;
        m_pos    = '0;
        m_dir    = 1'b0;
        m_errcnt = 0;
        m_fault  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        checkpoint("after_reset_release");
        repeat (6) tick();
        checkpoint("held_constant");

        // Randomized walk with occasional clears and illegal jumps.
        for (int k = 0; k < 300; k++) begin
            int r;
            int h;
            r = $urandom_range(0, 99);
            h = $urandom_range(1, 3);
            if (r < 40) begin
                drive(m_val + 1, h);
            end else if (r < 80) begin
                drive(m_val - 1, h);
            end else if (r < 88) begin
                drive(m_val, h);
            end else if (r < 92) begin
                step_clr(r[0]);
            end else begin
                drive(m_val + $urandom_range(2, MASK - 1), h);
                checkpoint("rand_fault");
                clear_pulse();
                checkpoint("rand_clear");
            end
        end
        checkpoint("rand_end");

        // Saturate the error counter.
        for (int k = 0; k < 300; k++) begin
            drive(m_val + $urandom_range(2, MASK - 1), S + 3);
            clear_pulse();
            repeat (2) tick();
        end
        checkpoint("err_sat");
        chk("err_cnt_saturated", err_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
